ov7670_stream_gen: RTL and testbench
====================================

# ov7670_stream_gen

Synthesizable OV7670-style camera stream transmitter. It drives VSYNC/HREF/8-bit data in the sensor's RGB444 byte format, so the capture path (pixel capture → image buffer → filter chain) can run and be verified without a physical camera. It sits in place of the OV7670 pins, on the capture clock, and generates colour bars, gradient, checkerboard or solid frames with sensor-like frame and line timing.

## Interface
- IMG_W, 640, active pixels per line; multiple of 8, ≥ 8
- IMG_H, 480, active lines per frame; ≥ 1
- HBLANK_BYTES, 288, idle byte slots after each active line's data; ≥ 1
- VS_LINES, 3, line periods with vsync high
- VBP_LINES, 17, blank line periods after vsync, before first active line
- VFP_LINES, 10, blank line periods after last active line
- clk  in  1  byte clock (one output byte per cycle; consumer samples on the same clock)
- rst  in  1  asynchronous, active-high reset
- enable  in  1  run request; sampled at frame boundaries only
- mode  in  2  0 colour bars, 1 grey gradient, 2 checkerboard, 3 solid
- solid_rgb  in  12  {R,G,B} 4 bits each, used in mode 3
- vsync  out  1  frame sync, high during VS lines
- href  out  1  high while active pixel bytes are on d
- d  out  8  pixel byte; 0 whenever href low
- frame_done  out  1  one-cycle pulse on the last cycle of a frame's VFP
- frame_count  out  16  completed frames, wraps at 0xFFFF → 0

## Operation
- Line period L = 2·IMG_W + HBLANK_BYTES cycles; frame period F = (VS_LINES + VBP_LINES + IMG_H + VFP_LINES)·L.
- Counters: hcnt 0..L−1, vcnt 0..(lines−1), pixel x = hcnt>>1 during active bytes, y = active line index.
- FSM: IDLE, VSYNC, VBP, ACTIVE, VFP. IDLE→VSYNC when enable=1; VSYNC→VBP after VS_LINES·L cycles; VBP→ACTIVE after VBP_LINES·L; ACTIVE→VFP after IMG_H·L; VFP→VSYNC if enable=1 at the last VFP cycle, else →IDLE. Zero-length VBP/VFP states are skipped.
- mode and solid_rgb latched on IDLE→VSYNC and VFP→VSYNC; changes mid-frame have no effect until next frame.
- enable deasserted mid-frame: current frame completes fully, then IDLE.
- Byte order per pixel: even byte {4'h0, R}, odd byte {G, B}.
- Mode 0: 8 equal bars of IMG_W/8 pixels, left→right white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000. Bar index from a per-pixel down-counter, no divider.
- Mode 1: R=G=B=x[8:5] (wraps every 512 pixels).
- Mode 2: FFF when x[5]^y[5]=1, else 000.
- Mode 3: solid_rgb every pixel.
- href high exactly for hcnt 0..2·IMG_W−1 of ACTIVE lines; low in HBLANK and all non-ACTIVE states.
- frame_count increments in the same cycle frame_done is high.

## Timing
- Reset: vsync=0, href=0, d=0, frame_done=0, frame_count=0, FSM=IDLE, counters 0.
- All outputs registered. enable seen high in IDLE at cycle n → vsync=1 from cycle n+1 for VS_LINES·L cycles.
- First href rising edge occurs (VS_LINES+VBP_LINES)·L cycles after vsync rises; d on that cycle is pixel (0,0) even byte.
- href and d change in the same cycle; no byte of a pixel is ever split across lines.
- Back-to-back frames: vsync rises the cycle after frame_done; period exactly F cycles.
- Reset asserted mid-frame: all outputs return to reset values immediately (async), restart only via IDLE→VSYNC after release.

## Test plan
Use IMG_W=16, IMG_H=4, HBLANK_BYTES=8, VS/VBP/VFP_LINES=1 (L=40, F=280).
- Reset, enable=1 at cycle 0, mode=0 → vsync high cycles 1–40; href first high cycle 81 for 32 cycles; bytes 0F,FF,0F,FF,0F,F0,… (2 pixels per bar), last two pixels 00,00.
- mode=3, solid_rgb=0xA5C → every active pixel 0A,5C; 4 href pulses of 32 cycles, 8-cycle gaps; d=0 whenever href=0.
- Continuous enable for 3 frames → frame_done pulses at cycles 280, 560, 840; frame_count 1,2,3; vsync period 280.
- enable dropped at cycle 100 → frame ends normally at 280, frame_count=1, no further vsync; re-enable restarts with vsync one cycle later.
- mode changed 0→2 mid-frame → current frame stays colour bars; next frame checkerboard (16×4 frame: all pixels 000 since x[5]=y[5]=0).
- rst pulsed at cycle 150 → vsync/href/d/frame_count = 0 same cycle; with enable held high, new frame's vsync rises one cycle after release.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_stream_gen
// Purpose  : OV7670-style camera stream transmitter. Emits VSYNC / HREF and
//            8-bit RGB444 bytes (even byte {0,R}, odd byte {G,B}) with
//            sensor-like frame and line timing, so the capture path can be
//            exercised without a physical camera. Patterns: colour bars,
//            grey gradient, checkerboard, solid colour.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1   byte clock, one output byte per cycle
//   rst          in   1   asynchronous, active-high reset
//   enable       in   1   run request, sampled at frame boundaries only
//   mode         in   2   0 bars, 1 gradient, 2 checkerboard, 3 solid
//   solid_rgb    in  12   {R,G,B} colour used by mode 3
//   vsync        out  1   high during the VS line periods
//   href         out  1   high while active pixel bytes are on d
//   d            out  8   pixel byte, 0 whenever href is low
//   frame_done   out  1   one-cycle pulse on the final cycle of a frame
//   frame_count  out 16   completed frames, wraps 0xFFFF -> 0
// ============================================================================
module ov7670_stream_gen #(
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int HBLANK_BYTES = 288,
  parameter int VS_LINES     = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_line_len = 2 * IMG_W + HBLANK_BYTES;

  // hcnt is kept at least 10 bits wide so pixel-x bits [8:5] (hcnt[9:6])
  // always exist for the gradient pattern even on narrow test images.
  localparam int c_hw = ($clog2(c_line_len) > 10) ? $clog2(c_line_len) : 10;

  localparam int c_max_a    = (VS_LINES  > VBP_LINES) ? VS_LINES  : VBP_LINES;
  localparam int c_max_b    = (IMG_H     > VFP_LINES) ? IMG_H     : VFP_LINES;
  localparam int c_max_lines = (c_max_a > c_max_b) ? c_max_a : c_max_b;

  // vcnt holds the active line index in ACTIVE; y[5] must always exist.
  localparam int c_vw = ($clog2(c_max_lines) > 6) ? $clog2(c_max_lines) : 6;

  localparam int c_bar_w = IMG_W / 8;
  localparam int c_bw    = (c_bar_w > 1) ? $clog2(c_bar_w) : 1;

  localparam logic [c_hw-1:0] c_h_last   = c_hw'(c_line_len - 1);
  localparam logic [c_hw-1:0] c_h_act    = c_hw'(2 * IMG_W);
  localparam logic [c_vw-1:0] c_vs_last  = c_vw'(VS_LINES - 1);
  localparam logic [c_vw-1:0] c_vbp_last = c_vw'(VBP_LINES - 1);
  localparam logic [c_vw-1:0] c_act_last = c_vw'(IMG_H - 1);
  localparam logic [c_vw-1:0] c_vfp_last = c_vw'(VFP_LINES - 1);
  localparam logic [c_bw-1:0] c_bar_reload = c_bw'(c_bar_w - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  // The last state of a frame; VFP is skipped entirely when it has no lines.
  localparam state_t          c_final_state = (VFP_LINES > 0) ? S_VFP : S_ACTIVE;
  localparam logic [c_vw-1:0] c_final_last  = (VFP_LINES > 0) ? c_vfp_last : c_act_last;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_hw-1:0] r_hcnt;
  logic [c_vw-1:0] r_vcnt;
  logic [2:0]      r_bar_idx;
  logic [c_bw-1:0] r_bar_cnt;
  logic [1:0]      r_mode;
  logic [11:0]     r_solid;

  // Next position: the registered outputs are always computed from the
  // position the generator is about to occupy, so every output lines up
  // with the state/counters of the same cycle.
  state_t          w_nstate;
  logic [c_hw-1:0] w_nhcnt;
  logic [c_vw-1:0] w_nvcnt;
  logic [c_vw-1:0] w_last_line;
  logic            w_latch;
  logic            w_nact;
  logic            w_nlast;
  logic [2:0]      w_nbar_idx;
  logic [c_bw-1:0] w_nbar_cnt;
  logic [11:0]     w_rgb;
  logic [7:0]      w_byte;

  // --------------------------------------------------------------------------
  // Frame / line sequencing
  // --------------------------------------------------------------------------
  always_comb begin
    w_nstate    = r_state;
    w_nhcnt     = r_hcnt;
    w_nvcnt     = r_vcnt;
    w_latch     = 1'b0;
    w_last_line = '0;

    case (r_state)
      S_VSYNC:  w_last_line = c_vs_last;
      S_VBP:    w_last_line = c_vbp_last;
      S_ACTIVE: w_last_line = c_act_last;
      S_VFP:    w_last_line = c_vfp_last;
      default:  w_last_line = '0;
    endcase

    if (r_state == S_IDLE) begin
      if (enable) begin
        w_nstate = S_VSYNC;
        w_nhcnt  = '0;
        w_nvcnt  = '0;
        w_latch  = 1'b1;
      end
    end else if (r_hcnt != c_h_last) begin
      w_nhcnt = r_hcnt + 1'b1;
    end else begin
      w_nhcnt = '0;
      if (r_vcnt != w_last_line) begin
        w_nvcnt = r_vcnt + 1'b1;
      end else begin
        w_nvcnt = '0;
        case (r_state)
          S_VSYNC:  w_nstate = (VBP_LINES > 0) ? S_VBP : S_ACTIVE;
          S_VBP:    w_nstate = S_ACTIVE;
          S_ACTIVE: w_nstate = (VFP_LINES > 0) ? S_VFP : S_IDLE;
          default:  w_nstate = S_IDLE;
        endcase
        // Frame boundary: enable is only looked at here (and in IDLE).
        if (w_nstate == S_IDLE && enable) begin
          w_nstate = S_VSYNC;
          w_latch  = 1'b1;
        end
      end
    end
  end

  assign w_nact  = (w_nstate == S_ACTIVE) && (w_nhcnt < c_h_act);
  assign w_nlast = (w_nstate == c_final_state) && (w_nhcnt == c_h_last) &&
                   (w_nvcnt == c_final_last);

  // --------------------------------------------------------------------------
  // Colour-bar tracking: a per-pixel down-counter steps the bar index every
  // IMG_W/8 pixels, avoiding a divider on x.
  // --------------------------------------------------------------------------
  always_comb begin
    w_nbar_idx = r_bar_idx;
    w_nbar_cnt = r_bar_cnt;
    if (w_nact && !w_nhcnt[0]) begin
      if (w_nhcnt == '0) begin
        w_nbar_idx = 3'd0;
        w_nbar_cnt = c_bar_reload;
      end else if (r_bar_cnt == '0) begin
        w_nbar_idx = r_bar_idx + 1'b1;
        w_nbar_cnt = c_bar_reload;
      end else begin
        w_nbar_cnt = r_bar_cnt - 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel colour and byte selection
  // x = hcnt >> 1, so x[5] = hcnt[6] and x[8:5] = hcnt[9:6]; y = vcnt.
  // --------------------------------------------------------------------------
  always_comb begin
    w_rgb = 12'h000;
    case (r_mode)
      2'd0: begin
        case (w_nbar_idx)
          3'd0:    w_rgb = 12'hFFF;
          3'd1:    w_rgb = 12'hFF0;
          3'd2:    w_rgb = 12'h0FF;
          3'd3:    w_rgb = 12'h0F0;
          3'd4:    w_rgb = 12'hF0F;
          3'd5:    w_rgb = 12'hF00;
          3'd6:    w_rgb = 12'h00F;
          default: w_rgb = 12'h000;
        endcase
      end
      2'd1:    w_rgb = {w_nhcnt[9:6], w_nhcnt[9:6], w_nhcnt[9:6]};
      2'd2:    w_rgb = (w_nhcnt[6] ^ w_nvcnt[5]) ? 12'hFFF : 12'h000;
      default: w_rgb = r_solid;
    endcase
  end

  assign w_byte = w_nhcnt[0] ? w_rgb[7:0] : {4'h0, w_rgb[11:8]};

  // --------------------------------------------------------------------------
  // Registers and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_bar_idx   <= 3'd0;
      r_bar_cnt   <= '0;
      r_mode      <= 2'd0;
      r_solid     <= 12'h000;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      r_state   <= w_nstate;
      r_hcnt    <= w_nhcnt;
      r_vcnt    <= w_nvcnt;
      r_bar_idx <= w_nbar_idx;
      r_bar_cnt <= w_nbar_cnt;
      // Pattern selection is frozen for the whole frame.
      if (w_latch) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
      vsync      <= (w_nstate == S_VSYNC);
      href       <= w_nact;
      d          <= w_nact ? w_byte : 8'h00;
      frame_done <= w_nlast;
      if (w_nlast) begin
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ov7670_stream_gen
// Purpose  : Self-checking bench for ov7670_stream_gen. A frame-position
//            reference model (single cycle counter within the frame, decoded
//            with division/modulo) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ov7670_stream_gen;

  localparam int W   = 16;
  localparam int H   = 4;
  localparam int HB  = 8;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int VFP = 1;
  localparam int L   = 2 * W + HB;
  localparam int F   = (VS + VBP + H + VFP) * L;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic        frame_done;
  logic [15:0] frame_count;

  ov7670_stream_gen #(
    .IMG_W(W), .IMG_H(H), .HBLANK_BYTES(HB),
    .VS_LINES(VS), .VBP_LINES(VBP), .VFP_LINES(VFP)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_rgb(solid_rgb),
    .vsync(vsync), .href(href), .d(d), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_run;
  int          m_p;
  logic [1:0]  m_mode;
  logic [11:0] m_solid;
  logic [15:0] m_cnt;

  int cyc;
  int first_href;
  int last_fd;
  int last_vs_rise;
  logic prev_vs;

  logic [11:0] bars [0:7] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    case (m_mode)
      2'd0:    return bars[x / (W / 8)];
      2'd1:    return {3{4'((x >> 5) & 15)}};
      2'd2:    return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      default: return m_solid;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_p   = 0;
    m_cnt = 16'h0;
  endtask

  // Advance the model by one clock edge, using the inputs seen at that edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; m_p = 0; m_mode = mode; m_solid = solid_rgb;
      end
    end else if (m_p == F - 1) begin
      if (enable) begin
        m_p = 0; m_mode = mode; m_solid = solid_rgb;
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_p++;
    end
    if (m_run && m_p == F - 1) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic check_all();
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_d;
    logic [11:0] rgb;
    int line, h, a;
    e_vs = 1'b0; e_hr = 1'b0; e_fd = 1'b0; e_d = 8'h00;
    if (m_run) begin
      line = m_p / L;
      h    = m_p % L;
      a    = line - (VS + VBP);
      e_vs = (line < VS);
      e_fd = (m_p == F - 1);
      if (a >= 0 && a < H && h < 2 * W) begin
        e_hr = 1'b1;
        rgb  = pix(h / 2, a);
        e_d  = (h % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
      end
    end
    chk($sformatf("vsync@%0d", cyc), 32'(vsync), 32'(e_vs));
    chk($sformatf("href@%0d", cyc), 32'(href), 32'(e_hr));
    chk($sformatf("d@%0d", cyc), 32'(d), 32'(e_d));
    chk($sformatf("frame_done@%0d", cyc), 32'(frame_done), 32'(e_fd));
    chk($sformatf("frame_count@%0d", cyc), 32'(frame_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (href && first_href < 0) first_href = cyc;
    if (frame_done) last_fd = cyc;
    if (vsync && !prev_vs) last_vs_rise = cyc;
    prev_vs = vsync;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; solid_rgb = 12'h000;
    model_reset();
    m_mode = 2'd0; m_solid = 12'h000;
    cyc = 0; first_href = -1; last_fd = -1; last_vs_rise = -1; prev_vs = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vsync", 32'(vsync), 0);
    chk("rst_href", 32'(href), 0);
    chk("rst_d", 32'(d), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    rst = 1'b0;
    run(3);

    // Frame 1: colour bars; mode switched to checkerboard mid-frame.
    enable = 1'b1; mode = 2'd0; cyc = 0; prev_vs = 1'b0;
    run(100);
    mode = 2'd2;
    run(180);
    chk("first_vs_rise", 32'(last_vs_rise), 1);
    chk("first_href", 32'(first_href), 81);
    chk("fd1_cycle", 32'(last_fd), 280);
    chk("count_after_f1", 32'(frame_count), 1);

    // Frame 2: checkerboard; solid requested mid-frame for frame 3.
    run(20);
    mode = 2'd3; solid_rgb = 12'hA5C;
    run(260);
    chk("vs_rise_f2", 32'(last_vs_rise), 281);
    chk("fd2_cycle", 32'(last_fd), 560);

    // Frame 3: solid A5C; enable dropped mid-frame.
    run(140);
    enable = 1'b0;
    run(140);
    chk("vs_rise_f3", 32'(last_vs_rise), 561);
    chk("fd3_cycle", 32'(last_fd), 840);
    chk("count_after_f3", 32'(frame_count), 3);
    run(60);
    chk("no_vs_after_drop", 32'(last_vs_rise), 561);

    // Re-enable: vsync on the next cycle.
    enable = 1'b1; mode = 2'($urandom_range(0, 3)); solid_rgb = 12'($urandom);
    cyc = 0;
    step();
    chk("reenable_vsync", 32'(vsync), 1);
    run(F - 1);

    // Randomized frames: mid-frame pattern changes and enable toggles.
    for (int f = 0; f < 6; f++) begin
      int k1, k2;
      k1 = $urandom_range(0, F - 1);
      k2 = $urandom_range(0, F - 1);
      for (int i = 0; i < F; i++) begin
        if (i == k1) begin
          mode = 2'($urandom_range(0, 3)); solid_rgb = 12'($urandom);
        end
        if (i == k2) enable = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    // Asynchronous reset in the middle of a frame.
    enable = 1'b1; mode = 2'd3; solid_rgb = 12'hA5C | 12'($urandom_range(1, 4095));
    run(2 * F);
    while (vsync) step();
    while (!vsync) step();
    cyc = 1;
    run(149);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_vsync", 32'(vsync), 0);
    chk("async_rst_href", 32'(href), 0);
    chk("async_rst_d", 32'(d), 0);
    chk("async_rst_count", 32'(frame_count), 0);
    step();
    rst = 1'b0;
    step();
    chk("vs_after_release", 32'(vsync), 1);
    run(F + 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
